// File: rtl/wb_host_initiator.sv
// wb_host_initiator
// Wishbone B4 classic single-transfer initiator. Each command accepted on the
// cmd_* valid/ready stream becomes exactly one bus cycle on wbm_*. The result
// (read data, or a timeout error) is returned on the rsp_* valid/ready stream.
// At most one transfer is outstanding: no new command is accepted until the
// response has been consumed.
//
// Ports
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   cmd_valid_i/ready_o command handshake
//   cmd_we_i            1 = write, 0 = read
//   cmd_adr_i/dat_i     byte address, write data
//   cmd_sel_i           byte enables
//   rsp_valid_o/ready_i response handshake
//   rsp_dat_o           read data (0 for writes and errors)
//   rsp_err_o           1 = bus cycle timed out without ack
//   wbm_*               Wishbone master port
//
// State | meaning
// ------+----------------------------------------------------------
// IDLE  | ready for a command; no bus cycle
// BUS   | cyc/stb asserted, waiting for ack or timeout
// RESP  | response presented, waiting for rsp_ready_i
module wb_host_initiator #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_we_i,
    input  logic [AW-1:0]   cmd_adr_i,
    input  logic [DW-1:0]   cmd_dat_i,
    input  logic [DW/8-1:0] cmd_sel_i,

    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [DW-1:0]   rsp_dat_o,
    output logic            rsp_err_o,

    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [DW/8-1:0] wbm_sel_o,
    output logic [AW-1:0]   wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    input  logic [DW-1:0]   wbm_dat_i,
    input  logic            wbm_ack_i
);

    localparam int unsigned SW = DW / 8;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [DW-1:0]   rsp_dat_q, rsp_dat_d;
    logic            rsp_err_q, rsp_err_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    we_d    = cmd_we_i;
                    adr_d   = cmd_adr_i;
                    dat_d   = cmd_dat_i;
                    sel_d   = cmd_sel_i;
                    cnt_d   = '0;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                // Ack is checked first so an ack on the timeout edge wins.
                if (wbm_ack_i) begin
                    rsp_dat_d = we_q ? '0 : wbm_dat_i;
                    rsp_err_d = 1'b0;
                    state_d   = ST_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th BUS cycle without ack.
                    cnt_d     = CW'(TIMEOUT);
                    rsp_dat_d = '0;
                    rsp_err_d = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    cnt_d     = '0;
                    rsp_dat_d = '0;
                    rsp_err_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake and strobe outputs decode straight from the state register,
    // so an asynchronous reset drops cyc/stb/rsp_valid without a clock edge.
    assign cmd_ready_o = (state_q == ST_IDLE);
    assign rsp_valid_o = (state_q == ST_RESP);
    assign wbm_cyc_o   = (state_q == ST_BUS);
    assign wbm_stb_o   = (state_q == ST_BUS);

    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;

    assign wbm_we_o    = we_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign wbm_sel_o   = sel_q;

endmodule

// File: tb/tb_wb_host_initiator.sv
module tb_wb_host_initiator;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid8, cmd_valid4;
    logic        cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_ready;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack;

    logic        ready8, rv8, err8, cyc8, stb8, we8;
    logic [31:0] rdat8, adr8, wdat8;
    logic [3:0]  sel8;
    logic        ready4, rv4, err4, cyc4, stb4, we4;
    logic [31:0] rdat4, adr4, wdat4;
    logic [3:0]  sel4;

    bit          use4;
    logic        cur_ready, cur_rv, cur_err, cur_cyc, cur_stb, cur_we;
    logic [31:0] cur_rdat, cur_adr, cur_wdat;
    logic [3:0]  cur_sel;

    int n_cmp = 0;
    int n_err = 0;

    assign cur_ready = use4 ? ready4 : ready8;
    assign cur_rv    = use4 ? rv4    : rv8;
    assign cur_err   = use4 ? err4   : err8;
    assign cur_cyc   = use4 ? cyc4   : cyc8;
    assign cur_stb   = use4 ? stb4   : stb8;
    assign cur_we    = use4 ? we4    : we8;
    assign cur_rdat  = use4 ? rdat4  : rdat8;
    assign cur_adr   = use4 ? adr4   : adr8;
    assign cur_wdat  = use4 ? wdat4  : wdat8;
    assign cur_sel   = use4 ? sel4   : sel8;

    wb_host_initiator #(.AW(32), .DW(32), .TIMEOUT(8)) u_dut8 (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid8), .cmd_ready_o(ready8), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
        .rsp_valid_o(rv8), .rsp_ready_i(rsp_ready), .rsp_dat_o(rdat8), .rsp_err_o(err8),
        .wbm_cyc_o(cyc8), .wbm_stb_o(stb8), .wbm_we_o(we8), .wbm_sel_o(sel8),
        .wbm_adr_o(adr8), .wbm_dat_o(wdat8), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack)
    );

    wb_host_initiator #(.AW(32), .DW(32), .TIMEOUT(4)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid4), .cmd_ready_o(ready4), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
        .rsp_valid_o(rv4), .rsp_ready_i(rsp_ready), .rsp_dat_o(rdat4), .rsp_err_o(err4),
        .wbm_cyc_o(cyc4), .wbm_stb_o(stb4), .wbm_we_o(we4), .wbm_sel_o(sel4),
        .wbm_adr_o(adr4), .wbm_dat_o(wdat4), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command and let it be taken on the next edge.
    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
        cmd_we  = we;
        cmd_adr = adr;
        cmd_dat = dat;
        cmd_sel = sel;
        if (use4) cmd_valid4 = 1'b1; else cmd_valid8 = 1'b1;
        tick();
        cmd_valid8 = 1'b0;
        cmd_valid4 = 1'b0;
    endtask

    // Play a slave that acks in BUS cycle ack_at (0 = never). Measures cycles
    // with cyc high, edges from acceptance until rsp_valid, and bus stability.
    task automatic run_bus(input int ack_at, input logic [31:0] rdata, input int budget,
                           input logic [31:0] exp_adr, input logic exp_we,
                           output int cyc_cycles, output int lat,
                           output bit stable, output bit expired);
        int ticks;
        cyc_cycles = 0;
        ticks      = 0;
        stable     = 1'b1;
        expired    = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (cur_rv) begin
                expired = 1'b0;
                break;
            end
            if (cur_cyc) begin
                cyc_cycles++;
                if (cur_adr !== exp_adr || cur_we !== exp_we || cur_stb !== 1'b1) stable = 1'b0;
            end
            wbm_ack   = (ack_at != 0) && (cyc_cycles == ack_at);
            wbm_dat_i = wbm_ack ? rdata : 32'hBAD0_BAD0;
            tick();
            ticks++;
        end
        wbm_ack   = 1'b0;
        wbm_dat_i = 32'h0;
        lat = ticks + 1;   // counting the acceptance cycle itself
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_cmp++; if (ready8 !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", ready8); end
        n_cmp++; if (cyc8 !== 1'b0 || stb8 !== 1'b0) begin n_err++; $display("FAIL reset_cyc_stb: got %b%b want 00", cyc8, stb8); end
        n_cmp++; if (rv8 !== 1'b0 || err8 !== 1'b0) begin n_err++; $display("FAIL reset_rsp: got v=%b e=%b want 0 0", rv8, err8); end
        n_cmp++; if (rdat8 !== 32'h0 || adr8 !== 32'h0 || wdat8 !== 32'h0 || sel8 !== 4'h0 || we8 !== 1'b0)
            begin n_err++; $display("FAIL reset_regs: got rdat=%h adr=%h wdat=%h sel=%h we=%b want 0", rdat8, adr8, wdat8, sel8, we8); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_cmp++; if (ready8 !== 1'b1 || ready4 !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b/%b want 1/1", ready8, ready4); end
    endtask

    task automatic test_write_zero_wait();
        int cc, lat; bit st, exp_b;
        use4 = 1'b0;
        n_cmp++; if (cur_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready_idle: got %b want 1", cur_ready); end
        issue(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
        n_cmp++; if (cur_cyc !== 1'b1 || cur_ready !== 1'b0) begin n_err++; $display("FAIL wr_bus_entry: got cyc=%b ready=%b want 1 0", cur_cyc, cur_ready); end
        n_cmp++; if (cur_wdat !== 32'hDEAD_BEEF || cur_sel !== 4'hF) begin n_err++; $display("FAIL wr_bus_data: got %h/%h want deadbeef/f", cur_wdat, cur_sel); end
        run_bus(1, 32'hCAFE_F00D, 20, 32'h3000_0004, 1'b1, cc, lat, st, exp_b);
        n_cmp++; if (exp_b !== 1'b0) begin n_err++; $display("FAIL wr_no_response: got expired=%b want 0", exp_b); end
        n_cmp++; if (cc !== 1) begin n_err++; $display("FAIL wr_cyc_len: got %0d want 1", cc); end
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL wr_latency: got %0d want 2", lat); end
        n_cmp++; if (st !== 1'b1) begin n_err++; $display("FAIL wr_bus_stable: got %b want 1", st); end
        n_cmp++; if (cur_err !== 1'b0 || cur_rdat !== 32'h0) begin n_err++; $display("FAIL wr_rsp: got err=%b dat=%h want 0 0", cur_err, cur_rdat); end
        consume();
        n_cmp++; if (cur_rv !== 1'b0 || cur_ready !== 1'b1) begin n_err++; $display("FAIL wr_after_hs: got v=%b ready=%b want 0 1", cur_rv, cur_ready); end
    endtask

    task automatic test_read_wait();
        int cc, lat; bit st, exp_b;
        use4 = 1'b0;
        issue(1'b0, 32'h3000_0100, 32'h5555_AAAA, 4'h3);
        n_cmp++; if (cur_we !== 1'b0 || cur_sel !== 4'h3) begin n_err++; $display("FAIL rd_bus_ctrl: got we=%b sel=%h want 0 3", cur_we, cur_sel); end
        run_bus(4, 32'h1234_5678, 20, 32'h3000_0100, 1'b0, cc, lat, st, exp_b);
        n_cmp++; if (exp_b !== 1'b0) begin n_err++; $display("FAIL rd_no_response: got expired=%b want 0", exp_b); end
        n_cmp++; if (cc !== 4) begin n_err++; $display("FAIL rd_cyc_len: got %0d want 4", cc); end
        n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL rd_latency: got %0d want 5", lat); end
        n_cmp++; if (st !== 1'b1) begin n_err++; $display("FAIL rd_adr_stable: got %b want 1", st); end
        n_cmp++; if (cur_rdat !== 32'h1234_5678 || cur_err !== 1'b0) begin n_err++; $display("FAIL rd_rsp: got dat=%h err=%b want 12345678 0", cur_rdat, cur_err); end
        consume();
    endtask

    task automatic test_timeout();
        int cc, lat; bit st, exp_b;
        use4 = 1'b0;
        issue(1'b0, 32'h3000_0200, 32'h0, 4'hF);
        run_bus(0, 32'h0, 30, 32'h3000_0200, 1'b0, cc, lat, st, exp_b);
        n_cmp++; if (exp_b !== 1'b0) begin n_err++; $display("FAIL to_no_response: got expired=%b want 0", exp_b); end
        n_cmp++; if (cc !== 8) begin n_err++; $display("FAIL to_cyc_len: got %0d want 8", cc); end
        n_cmp++; if (cur_err !== 1'b1 || cur_rdat !== 32'h0) begin n_err++; $display("FAIL to_rsp: got err=%b dat=%h want 1 0", cur_err, cur_rdat); end
        n_cmp++; if (cur_cyc !== 1'b0) begin n_err++; $display("FAIL to_cyc_drop: got %b want 0", cur_cyc); end
        consume();
        issue(1'b0, 32'h3000_0204, 32'h0, 4'hF);
        run_bus(1, 32'h0BAD_CAFE, 20, 32'h3000_0204, 1'b0, cc, lat, st, exp_b);
        n_cmp++; if (exp_b !== 1'b0 || cur_rdat !== 32'h0BAD_CAFE || cur_err !== 1'b0)
            begin n_err++; $display("FAIL to_next_cmd: got expired=%b dat=%h err=%b want 0 0badcafe 0", exp_b, cur_rdat, cur_err); end
        consume();
    endtask

    task automatic test_backpressure();
        int cc, lat; bit st, exp_b;
        use4 = 1'b0;
        issue(1'b0, 32'h3000_0300, 32'h0, 4'hF);
        run_bus(2, 32'hA5A5_5A5A, 20, 32'h3000_0300, 1'b0, cc, lat, st, exp_b);
        n_cmp++; if (exp_b !== 1'b0) begin n_err++; $display("FAIL bp_no_response: got expired=%b want 0", exp_b); end
        cmd_we = 1'b1; cmd_adr = 32'h3000_0310; cmd_dat = 32'h0102_0304; cmd_sel = 4'hC;
        cmd_valid8 = 1'b1;
        rsp_ready  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (cur_rv !== 1'b1 || cur_rdat !== 32'hA5A5_5A5A || cur_err !== 1'b0 || cur_ready !== 1'b0 || cur_cyc !== 1'b0)
                begin n_err++; $display("FAIL bp_hold[%0d]: got v=%b dat=%h err=%b ready=%b cyc=%b want 1 a5a55a5a 0 0 0",
                                        i, cur_rv, cur_rdat, cur_err, cur_ready, cur_cyc); end
            tick();
        end
        consume();
        n_cmp++; if (cur_ready !== 1'b1 || cur_cyc !== 1'b0 || cur_rv !== 1'b0) begin n_err++; $display("FAIL bp_after_hs: got ready=%b cyc=%b v=%b want 1 0 0", cur_ready, cur_cyc, cur_rv); end
        tick();
        cmd_valid8 = 1'b0;
        n_cmp++; if (cur_cyc !== 1'b1 || cur_adr !== 32'h3000_0310 || cur_wdat !== 32'h0102_0304 || cur_sel !== 4'hC)
            begin n_err++; $display("FAIL bp_new_cmd: got cyc=%b adr=%h dat=%h sel=%h want 1 30000310 01020304 c", cur_cyc, cur_adr, cur_wdat, cur_sel); end
        run_bus(1, 32'hFFFF_FFFF, 20, 32'h3000_0310, 1'b1, cc, lat, st, exp_b);
        n_cmp++; if (exp_b !== 1'b0 || cur_rdat !== 32'h0 || lat !== 2) begin n_err++; $display("FAIL bp_new_rsp: got expired=%b dat=%h lat=%0d want 0 0 2", exp_b, cur_rdat, lat); end
        consume();
    endtask

    task automatic test_ack_on_timeout_edge();
        int cc, lat; bit st, exp_b;
        use4 = 1'b1;
        issue(1'b0, 32'h3000_0400, 32'h0, 4'hF);
        run_bus(4, 32'h600D_F00D, 20, 32'h3000_0400, 1'b0, cc, lat, st, exp_b);
        n_cmp++; if (exp_b !== 1'b0 || cc !== 4) begin n_err++; $display("FAIL edge_cyc_len: got expired=%b cyc=%0d want 0 4", exp_b, cc); end
        n_cmp++; if (cur_err !== 1'b0 || cur_rdat !== 32'h600D_F00D) begin n_err++; $display("FAIL edge_ack_wins: got err=%b dat=%h want 0 600df00d", cur_err, cur_rdat); end
        consume();
        issue(1'b0, 32'h3000_0404, 32'h0, 4'hF);
        run_bus(0, 32'h0, 20, 32'h3000_0404, 1'b0, cc, lat, st, exp_b);
        n_cmp++; if (exp_b !== 1'b0 || cc !== 4 || cur_err !== 1'b1) begin n_err++; $display("FAIL edge_timeout4: got expired=%b cyc=%0d err=%b want 0 4 1", exp_b, cc, cur_err); end
        consume();
        // u_dut8 sat idle while the acks above were driven.
        n_cmp++; if (rv8 !== 1'b0 || cyc8 !== 1'b0) begin n_err++; $display("FAIL stray_ack_idle: got v=%b cyc=%b want 0 0", rv8, cyc8); end
        use4 = 1'b0;
    endtask

    task automatic test_reset_mid_bus();
        use4 = 1'b0;
        issue(1'b0, 32'h3000_0500, 32'h0, 4'hF);
        tick();
        n_cmp++; if (cyc8 !== 1'b1) begin n_err++; $display("FAIL rst_pre_cyc: got %b want 1", cyc8); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (cyc8 !== 1'b0 || stb8 !== 1'b0 || rv8 !== 1'b0) begin n_err++; $display("FAIL rst_async_drop: got cyc=%b stb=%b v=%b want 0 0 0", cyc8, stb8, rv8); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_cmp++; if (ready8 !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", ready8); end
        wbm_ack   = 1'b1;
        wbm_dat_i = 32'h1111_2222;
        tick();
        tick();
        n_cmp++; if (rv8 !== 1'b0 || cyc8 !== 1'b0 || rdat8 !== 32'h0) begin n_err++; $display("FAIL rst_stray_ack: got v=%b cyc=%b dat=%h want 0 0 0", rv8, cyc8, rdat8); end
        wbm_ack   = 1'b0;
        wbm_dat_i = 32'h0;
    endtask

    initial begin
        rst_n      = 1'b0;
        cmd_valid8 = 1'b0;
        cmd_valid4 = 1'b0;
        cmd_we     = 1'b0;
        cmd_adr    = 32'h0;
        cmd_dat    = 32'h0;
        cmd_sel    = 4'h0;
        rsp_ready  = 1'b0;
        wbm_dat_i  = 32'h0;
        wbm_ack    = 1'b0;
        use4       = 1'b0;
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_timeout();
        test_backpressure();
        test_ack_on_timeout_edge();
        test_reset_mid_bus();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
